// File: rtl/ptch_pid_duty.sv
// Pitch-loop PID and motor-duty generator.
// Stage 0 saturates the raw pitch sample to 10 bits. Stage 1 updates the
// anti-windup integrator and forms the derivative against a circular
// history. Stage 2 forms P+I+D and converts it to an offset, clamped duty
// with a direction bit.
module ptch_pid_duty #(
  parameter int          PTCH_W   = 16,
  parameter int          D_DEPTH  = 4,
  parameter int          D_GAIN   = 9,
  parameter int          I_SHIFT  = 1,
  parameter logic [11:0] MIN_DUTY = 12'h3D4,
  parameter logic [11:0] MAX_DUTY = 12'h7D0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic                     vld,
  input  logic                     pwr_up,
  input  logic                     rider_off,
  output logic [11:0]              mtr_duty,
  output logic                     rev,
  output logic                     duty_vld,
  output logic                     duty_sat
);

  localparam int PTR_W = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
  localparam logic signed [PTCH_W-1:0] ERR_MAX = PTCH_W'(511);
  localparam logic signed [PTCH_W-1:0] ERR_MIN = PTCH_W'(-512);

  // ---------------- Stage 0 ----------------
  logic signed [9:0] err_sat;

  // Clip the raw sample into the signed 10-bit working range.
  always_comb begin
    err_sat = ptch[9:0];
    if (ptch > ERR_MAX)
      err_sat = 10'h1FF;
    else if (ptch < ERR_MIN)
      err_sat = 10'h200;
  end

  // ---------------- Stage 1: integrator ----------------
  logic signed [17:0] acc_reg;
  logic signed [17:0] acc_next;
  logic signed [17:0] acc_sum;
  logic signed [17:0] err_ext;
  logic               acc_ovf;

  assign err_ext = {{8{err_sat[9]}}, err_sat};
  assign acc_sum = acc_reg + err_ext;
  // Same-sign operands producing a different-sign sum means the add wrapped.
  assign acc_ovf = (acc_reg[17] == err_ext[17]) && (acc_sum[17] != acc_reg[17]);

  // Clear dominates; otherwise accumulate on a sample unless it would wrap.
  always_comb begin
    acc_next = acc_reg;
    if (rider_off || !pwr_up)
      acc_next = '0;
    else if (vld && !acc_ovf)
      acc_next = acc_sum;
  end

  // ---------------- Stage 1: derivative history ----------------
  logic [PTR_W-1:0]  ptr_reg;
  logic signed [9:0] hist_vec [D_DEPTH];
  logic signed [9:0] hist_old;
  logic signed [10:0] diff_full;
  logic signed [6:0]  diff_sat;

  // The entry under the pointer is the oldest one; it is read for the
  // derivative and then overwritten by the newest sample.
  genvar gi;
  generate
    for (gi = 0; gi < D_DEPTH; gi++) begin : g_hist
      logic signed [9:0] ent_reg;

      // History entry gi: only reset clears it, written when the pointer selects it.
      always_ff @(posedge clk) begin
        if (rst)
          ent_reg <= '0;
        else if (vld && (ptr_reg == PTR_W'(gi)))
          ent_reg <= err_sat;
      end

      assign hist_vec[gi] = ent_reg;
    end
  endgenerate

  assign hist_old  = hist_vec[ptr_reg];
  assign diff_full = {err_sat[9], err_sat} - {hist_old[9], hist_old};

  // Saturate the 11-bit difference into signed 7 bits.
  always_comb begin
    diff_sat = diff_full[6:0];
    if (diff_full > 11'sd63)
      diff_sat = 7'h3F;
    else if (diff_full < -11'sd64)
      diff_sat = 7'h40;
  end

  logic signed [9:0] s1_err_reg;
  logic signed [9:0] s1_err_i_reg;
  logic signed [6:0] s1_diff_reg;
  logic              s1_vld_reg;

  // Stage-1 registers: integrator, history pointer and operands for stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      ptr_reg      <= '0;
      s1_err_reg   <= '0;
      s1_err_i_reg <= '0;
      s1_diff_reg  <= '0;
      s1_vld_reg   <= 1'b0;
    end else begin
      acc_reg    <= acc_next;
      s1_vld_reg <= vld;
      if (vld) begin
        s1_err_reg   <= err_sat;
        s1_err_i_reg <= acc_next[17:8];
        s1_diff_reg  <= diff_sat;
        ptr_reg      <= (ptr_reg == PTR_W'(D_DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
      end
    end
  end

  // ---------------- Stage 2: PID and duty ----------------
  logic signed [13:0] err14;
  logic signed [13:0] erri14;
  logic signed [13:0] diff14;
  logic signed [13:0] gain14;
  logic signed [13:0] p_term;
  logic signed [13:0] i_term;
  logic signed [13:0] d_term;
  logic signed [13:0] pid;
  logic [13:0]        pid_mag;
  logic [13:0]        duty_raw;
  logic               duty_clamp;

  assign err14   = {{4{s1_err_reg[9]}}, s1_err_reg};
  assign erri14  = {{4{s1_err_i_reg[9]}}, s1_err_i_reg};
  assign diff14  = {{7{s1_diff_reg[6]}}, s1_diff_reg};
  assign gain14  = 14'(D_GAIN);
  assign p_term  = (err14 >>> 1) + (err14 >>> 2);
  assign i_term  = erri14 >>> I_SHIFT;
  assign d_term  = diff14 * gain14;
  assign pid     = p_term + i_term + d_term;
  assign pid_mag = pid[13] ? 14'(-pid) : pid;
  assign duty_raw   = {2'b00, MIN_DUTY} + pid_mag;
  assign duty_clamp = duty_raw > {2'b00, MAX_DUTY};

  // Output registers: update on a stage-1 sample, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtr_duty <= '0;
      rev      <= 1'b0;
      duty_sat <= 1'b0;
      duty_vld <= 1'b0;
    end else begin
      duty_vld <= s1_vld_reg;
      if (s1_vld_reg) begin
        if (!pwr_up) begin
          mtr_duty <= '0;
          rev      <= 1'b0;
          duty_sat <= 1'b0;
        end else begin
          mtr_duty <= duty_clamp ? MAX_DUTY : duty_raw[11:0];
          rev      <= pid[13];
          duty_sat <= duty_clamp;
        end
      end
    end
  end

endmodule

// File: tb/tb_ptch_pid_duty.sv
// Directed bench for ptch_pid_duty: two instances (default clamp and a
// 1500 clamp) share stimulus; expected values are hand-computed.
module tb_ptch_pid_duty;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] ptch = '0;
  logic               vld = 1'b0;
  logic               pwr_up = 1'b1;
  logic               rider_off = 1'b0;

  logic [11:0] duty_a, duty_b;
  logic        rev_a, rev_b, dvld_a, dvld_b, sat_a, sat_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ptch_pid_duty u_dut (
    .clk(clk), .rst(rst), .ptch(ptch), .vld(vld), .pwr_up(pwr_up),
    .rider_off(rider_off), .mtr_duty(duty_a), .rev(rev_a),
    .duty_vld(dvld_a), .duty_sat(sat_a)
  );

  ptch_pid_duty #(.MAX_DUTY(12'd1500)) u_dut_lo (
    .clk(clk), .rst(rst), .ptch(ptch), .vld(vld), .pwr_up(pwr_up),
    .rider_off(rider_off), .mtr_duty(duty_b), .rev(rev_b),
    .duty_vld(dvld_b), .duty_sat(sat_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One sample, then wait until its result is on the outputs.
  task automatic single(input int v);
    ptch = 16'(v);
    vld  = 1'b1;
    step();
    vld  = 1'b0;
    step();
  endtask

  initial begin
    int exp4[6];
    exp4 = '{1697, 1697, 1698, 1698, 1131, 1132};

    // Reset state
    do_reset();
    chk("rst_duty", int'(duty_a), 0);
    chk("rst_rev", int'(rev_a), 0);
    chk("rst_vld", int'(dvld_a), 0);
    chk("rst_sat", int'(sat_a), 0);

    // Test 1 / 3: ptch=100
    single(100);
    chk("t1_vld", int'(dvld_a), 1);
    chk("t1_duty", int'(duty_a), 1622);
    chk("t1_rev", int'(rev_a), 0);
    chk("t1_sat", int'(sat_a), 0);
    chk("t3_duty", int'(duty_b), 1500);
    chk("t3_sat", int'(sat_b), 1);
    step();
    chk("t1_vld_drop", int'(dvld_a), 0);
    chk("t1_hold", int'(duty_a), 1622);

    // Test 2: ptch=-1000 saturates to -512
    do_reset();
    single(-1000);
    chk("t2_vld", int'(dvld_a), 1);
    chk("t2_duty", int'(duty_a), 1941);
    chk("t2_rev", int'(rev_a), 1);
    chk("t2_sat", int'(sat_a), 0);
    chk("t2_lo_duty", int'(duty_b), 1500);
    chk("t2_lo_rev", int'(rev_b), 1);

    // Test 4: step of 200, back-to-back samples
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        ptch = 16'sd200;
        vld  = 1'b1;
      end else begin
        vld = 1'b0;
      end
      step();
      if (k >= 1) begin
        chk($sformatf("t4_vld[%0d]", k - 1), int'(dvld_a), 1);
        chk($sformatf("t4_duty[%0d]", k - 1), int'(duty_a), exp4[k - 1]);
      end
    end
    chk("t4_lo_sat_last", int'(sat_b), 0);

    // Test 5: windup with 300 samples of 511
    do_reset();
    for (int k = 0; k <= 300; k++) begin
      if (k < 300) begin
        ptch = 16'sd511;
        vld  = 1'b1;
      end else begin
        vld = 1'b0;
      end
      step();
      if (k == 1)   chk("t5_s1", int'(duty_a), 1929);
      if (k == 255) chk("t5_s255", int'(duty_a), 1616);
      if (k == 256) chk("t5_s256", int'(duty_a), 1617);
      if (k == 257) chk("t5_s257", int'(duty_a), 1617);
      if (k == 300) chk("t5_final", int'(duty_a), 1617);
    end

    // Test 6: rider_off clears the integrator
    rider_off = 1'b1;
    step();
    rider_off = 1'b0;
    single(511);
    chk("t6_clr_duty", int'(duty_a), 1362);

    // pwr_up=0 forces outputs off while still pulsing duty_vld
    pwr_up = 1'b0;
    single(-1000);
    chk("t6_off_vld", int'(dvld_a), 1);
    chk("t6_off_duty", int'(duty_a), 0);
    chk("t6_off_rev", int'(rev_a), 0);
    chk("t6_off_lo_sat", int'(sat_b), 0);
    pwr_up = 1'b1;
    step();

    // Back on: history holds [511,511,511,-512], integrator was cleared
    single(100);
    chk("t6_on_duty", int'(duty_a), 1481);
    chk("t6_on_rev", int'(rev_a), 1);
    chk("t6_on_lo_sat", int'(sat_b), 0);

    // rst the cycle after vld discards the in-flight sample
    ptch = 16'sd100;
    vld  = 1'b1;
    step();
    vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_vld0", int'(dvld_a), 0);
    chk("t6_rst_duty", int'(duty_a), 0);
    chk("t6_rst_rev", int'(rev_a), 0);
    step();
    chk("t6_rst_vld1", int'(dvld_a), 0);
    chk("t6_rst_duty1", int'(duty_a), 0);
    step();
    chk("t6_rst_vld2", int'(dvld_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
